// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped instruction cache.
//   - FSM state encoding (IDLE / MEM_READ / UPDATE)
//   - field widths of the CPU address split and of the memory block / CPU word
//   - word-select helper used to pick a 32-bit word out of a 128-bit line
package instruction_cache_pkg;

  localparam int TAG_W   = 3;
  localparam int IDX_W   = 3;
  localparam int BLOCK_W = 128;
  localparam int WORD_W  = 32;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    MEM_READ = 2'd1,
    UPDATE   = 2'd2
  } state_e;

  // Word w of a block occupies bits [32w+31:32w].
  function automatic logic [WORD_W-1:0] select_word(input logic [BLOCK_W-1:0] blk,
                                                    input logic [1:0]         w);
    logic [WORD_W-1:0] word;
    case (w)
      2'd0:    word = blk[31:0];
      2'd1:    word = blk[63:32];
      2'd2:    word = blk[95:64];
      default: word = blk[127:96];
    endcase
    return word;
  endfunction

endpackage

// File: rtl/instruction_cache_array.sv
// icache_array: valid/tag/data storage of the instruction cache.
// Ports:
//   clock, reset     - system clock; asynchronous active-low reset (clears valid bits only)
//   rd_index         - line selected for the lookup
//   rd_valid/rd_tag/rd_block - contents of the selected line, read combinationally
//   wr_en            - install a line at the next posedge
//   wr_index/wr_tag/wr_block - line to install
// Tags and data are not reset; a line is only trusted once its valid bit is set.
module icache_array
  import instruction_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [IDX_W-1:0]   rd_index,
  output logic               rd_valid,
  output logic [TAG_W-1:0]   rd_tag,
  output logic [BLOCK_W-1:0] rd_block,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_index,
  input  logic [TAG_W-1:0]   wr_tag,
  input  logic [BLOCK_W-1:0] wr_block
);

  logic [NUM_BLOCKS-1:0] valid_q;
  logic [TAG_W-1:0]      tag_q  [NUM_BLOCKS];
  logic [BLOCK_W-1:0]    data_q [NUM_BLOCKS];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_index] <= 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (wr_en) begin
      tag_q[wr_index]  <= wr_tag;
      data_q[wr_index] <= wr_block;
    end
  end

  assign rd_valid = valid_q[rd_index];
  assign rd_tag   = tag_q[rd_index];
  assign rd_block = data_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// instruction_cache: direct-mapped instruction cache, 8 lines x 16 bytes.
// Hits are served combinationally with no stall; a miss fetches one 128-bit block
// from instruction memory, installs it and then serves the word.
// Optional feature: define ICACHE_STATS_EN to add hit_count / miss_count outputs.
// Ports:
//   clock, reset   - system clock; asynchronous active-low reset
//   read, address  - CPU fetch request and 10-bit byte PC ([9:7] tag, [6:4] index, [3:2] word)
//   readinst       - fetched word (0 when the current lookup does not hit)
//   busywait       - CPU stall, high while a request is unresolved
//   mem_read, mem_address - block read request to instruction memory ({tag,index})
//   mem_readinst, mem_busywait - block from memory and its busy flag
//   hit_count, miss_count (ICACHE_STATS_EN only) - saturating 16-bit statistics
// Memory handshake: mem_read is held high with a stable mem_address for the whole
// request; the memory holds mem_busywait high while busy, and mem_busywait being low
// in MEM_READ means mem_readinst is valid (it stays valid through the UPDATE cycle).
// The FSM state is kept in state_q (type state_e) so checkers can bind to it.
module instruction_cache
  import instruction_cache_pkg::*;
#(
  parameter int NUM_BLOCKS = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic [9:0]         address,
  output logic [WORD_W-1:0]  readinst,
  output logic               busywait,
  output logic               mem_read,
  output logic [5:0]         mem_address,
  input  logic [BLOCK_W-1:0] mem_readinst,
  input  logic               mem_busywait
`ifdef ICACHE_STATS_EN
  ,
  output logic [15:0]        hit_count,
  output logic [15:0]        miss_count
`endif
);

  state_e state_q, state_d;

  logic [TAG_W-1:0]       addr_tag;
  logic [IDX_W-1:0]       addr_idx;
  logic [1:0]             addr_word;
  logic                   addr_byte_unused;

  logic                   line_valid;
  logic [TAG_W-1:0]       line_tag;
  logic [BLOCK_W-1:0]     line_block;
  logic                   hit;

  logic [TAG_W+IDX_W-1:0] blk_addr_q;
  logic                   latch_blk;
  logic                   fill_en;

  assign addr_tag         = address[9:7];
  assign addr_idx         = address[6:4];
  assign addr_word        = address[3:2];
  assign addr_byte_unused = ^address[1:0];

  icache_array #(
    .NUM_BLOCKS(NUM_BLOCKS)
  ) u_array (
    .clock    (clock),
    .reset    (reset),
    .rd_index (addr_idx),
    .rd_valid (line_valid),
    .rd_tag   (line_tag),
    .rd_block (line_block),
    .wr_en    (fill_en),
    .wr_index (blk_addr_q[IDX_W-1:0]),
    .wr_tag   (blk_addr_q[TAG_W+IDX_W-1:IDX_W]),
    .wr_block (mem_readinst)
  );

  assign hit = line_valid && (line_tag == addr_tag);

  // State register and the block address latched at the start of a miss.
  // The fill always targets blk_addr_q, so the CPU address may wander mid-miss.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      blk_addr_q <= '0;
    end else begin
      state_q <= state_d;
      if (latch_blk) begin
        blk_addr_q <= {addr_tag, addr_idx};
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    latch_blk = 1'b0;
    case (state_q)
      IDLE: begin
        if (read && !hit) begin
          state_d   = MEM_READ;
          latch_blk = 1'b1;
        end
      end
      MEM_READ: begin
        if (!mem_busywait) begin
          state_d = UPDATE;
        end
      end
      UPDATE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign fill_en     = (state_q == UPDATE);
  assign mem_read    = (state_q == MEM_READ);
  assign mem_address = blk_addr_q;

  // Gated by reset so the stall drops the moment reset is asserted, even with read held.
  assign busywait = reset && read && !((state_q == IDLE) && hit);
  assign readinst = hit ? select_word(line_block, addr_word) : '0;

`ifdef ICACHE_STATS_EN
  logic [15:0] hit_count_q;
  logic [15:0] miss_count_q;
  logic        after_fill_q;

  // The first IDLE cycle after a fill is the tail of the miss, not a separate hit.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      hit_count_q  <= '0;
      miss_count_q <= '0;
      after_fill_q <= 1'b0;
    end else begin
      after_fill_q <= (state_q == UPDATE);
      if ((state_q == IDLE) && read && !hit && (miss_count_q != 16'hFFFF)) begin
        miss_count_q <= miss_count_q + 16'd1;
      end
      if ((state_q == IDLE) && read && hit && !after_fill_q && (hit_count_q != 16'hFFFF)) begin
        hit_count_q <= hit_count_q + 16'd1;
      end
    end
  end

  assign hit_count  = hit_count_q;
  assign miss_count = miss_count_q;
`endif

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with an instruction-memory model
// (mem_busywait follows mem_read and drops MEM_LAT cycles later with the block).
module tb_instruction_cache;

  localparam int MEM_LAT = 80;
  localparam int BUDGET  = 300;

  logic         clock = 1'b0;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic [31:0]  readinst;
  logic         busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readinst;
  logic         mem_busywait;
`ifdef ICACHE_STATS_EN
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;
`endif

  int vectors     = 0;
  int miscompares = 0;
  int exp_hits    = 0;
  int exp_misses  = 0;

  logic [31:0] exp_q[$];

  // ---------------- clock ----------------
  always #5 clock = ~clock;

  instruction_cache dut (
    .clock        (clock),
    .reset        (reset),
    .read         (read),
    .address      (address),
    .readinst     (readinst),
    .busywait     (busywait),
    .mem_read     (mem_read),
    .mem_address  (mem_address),
    .mem_readinst (mem_readinst),
    .mem_busywait (mem_busywait)
`ifdef ICACHE_STATS_EN
    ,
    .hit_count    (hit_count),
    .miss_count   (miss_count)
`endif
  );

  // ---------------- memory model ----------------
  function automatic logic [127:0] blk_data(input logic [5:0] b);
    logic [127:0] d;
    if (b == 6'h00) begin
      d = {32'h0C0D_0E0F, 32'h0206_0405, 32'h0005_0023, 32'h0004_0019};
    end else begin
      for (int w = 0; w < 4; w++) begin
        d[32*w +: 32] = {8'hA5, 2'b00, b, 14'd0, w[1:0]};
      end
    end
    return d;
  endfunction

  function automatic logic [31:0] word_of(input logic [9:0] a);
    logic [127:0] d;
    d = blk_data(a[9:4]);
    return d[32*a[3:2] +: 32];
  endfunction

  int   mem_cnt   = 0;
  logic mem_ready = 1'b0;

  always @(posedge clock) begin
    if (!mem_read) begin
      mem_cnt   <= 0;
      mem_ready <= 1'b0;
    end else if (!mem_ready) begin
      if (mem_cnt == MEM_LAT - 1) mem_ready <= 1'b1;
      mem_cnt <= mem_cnt + 1;
    end
  end

  assign mem_busywait = mem_read & ~mem_ready;
  assign mem_readinst = mem_ready ? blk_data(mem_address) : '0;

  // Length of the most recent low run of mem_read between two requests.
  int low_run  = 0;
  int last_gap = 0;
  always @(negedge clock) begin
    if (mem_read === 1'b1) begin
      if (low_run > 0) last_gap = low_run;
      low_run = 0;
    end else begin
      low_run++;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // One fetch: drive at negedge, sample #1 later; a miss is followed to completion.
  task automatic fetch(input string tag, input logic [9:0] a, input bit miss,
                       input logic [5:0] maddr, input logic [31:0] exp_word);
    int n;
    @(negedge clock);
    read    = 1'b1;
    address = a;
    exp_q.push_back(exp_word);
    if (miss) exp_misses++;
    else      exp_hits++;
    #1;
    check({tag, "_busy"}, {31'd0, busywait}, {31'd0, miss});
    if (miss) begin
      @(negedge clock); #1;
      check({tag, "_mem_read"}, {31'd0, mem_read}, 32'd1);
      check({tag, "_mem_addr"}, {26'd0, mem_address}, {26'd0, maddr});
      n = 0;
      while (busywait === 1'b1 && n < BUDGET) begin
        @(negedge clock); #1;
        n++;
      end
      check({tag, "_fill_in_budget"}, {31'd0, (n < BUDGET)}, 32'd1);
      check({tag, "_busy_after"}, {31'd0, busywait}, 32'd0);
    end
    check({tag, "_readinst"}, readinst, exp_q.pop_front());
  endtask

  task automatic idle_cycle();
    @(negedge clock);
    read = 1'b0;
    #1;
  endtask

  task automatic check_stats(input string tag);
`ifdef ICACHE_STATS_EN
    check({tag, "_miss_count"}, {16'd0, miss_count}, exp_misses);
    check({tag, "_hit_count"}, {16'd0, hit_count}, exp_hits);
`else
    check({tag, "_exp_q_empty"}, exp_q.size(), 32'd0);
`endif
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int n;
    reset   = 1'b0;
    read    = 1'b0;
    address = '0;
    @(negedge clock);
    @(negedge clock); #1;
    check("rst_busywait", {31'd0, busywait}, 32'd0);
    check("rst_mem_read", {31'd0, mem_read}, 32'd0);
    check("rst_mem_address", {26'd0, mem_address}, 32'd0);
    check("rst_readinst", readinst, 32'd0);
    reset = 1'b1;

    // 1 cold miss, 2 spatial hits
    fetch("cold_000", 10'h000, 1'b1, 6'h00, 32'h0004_0019);
    fetch("hit_004", 10'h004, 1'b0, 6'h00, 32'h0005_0023);
    fetch("hit_008", 10'h008, 1'b0, 6'h00, 32'h0206_0405);

    // 3 conflict misses on index 0
    fetch("conf_080", 10'h080, 1'b1, 6'h08, word_of(10'h080));
    fetch("conf_000", 10'h000, 1'b1, 6'h00, 32'h0004_0019);
    idle_cycle();
    check_stats("after_t3");

    // 4 back-to-back misses, then both lines hit
    fetch("b2b_010", 10'h010, 1'b1, 6'h01, word_of(10'h010));
    fetch("b2b_020", 10'h020, 1'b1, 6'h02, word_of(10'h020));
    check("b2b_mem_read_low_gap", {31'd0, (last_gap >= 1)}, 32'd1);
    fetch("b2b_hit_014", 10'h014, 1'b0, 6'h00, word_of(10'h014));
    fetch("b2b_hit_028", 10'h028, 1'b0, 6'h00, word_of(10'h028));

    // read dropped mid-miss: the line is still installed
    @(negedge clock);
    read    = 1'b1;
    address = 10'h040;
    exp_misses++;
    repeat (4) @(negedge clock);
    read = 1'b0;
    #1;
    check("drop_busy_low", {31'd0, busywait}, 32'd0);
    repeat (MEM_LAT + 10) @(negedge clock);
    fetch("drop_hit_044", 10'h044, 1'b0, 6'h00, word_of(10'h044));
    idle_cycle();
    check_stats("after_drop");

    // 5 reset 20 cycles into MEM_READ
    @(negedge clock);
    read    = 1'b1;
    address = 10'h030;
    n = 0;
    while (mem_read !== 1'b1 && n < BUDGET) begin
      @(negedge clock);
      n++;
    end
    check("rmm_enter_mem_read", {31'd0, (n < BUDGET)}, 32'd1);
    repeat (20) @(negedge clock);
    reset = 1'b0;
    #1;
    check("rmm_mem_read", {31'd0, mem_read}, 32'd0);
    check("rmm_busywait", {31'd0, busywait}, 32'd0);
    repeat (2) @(negedge clock);
    reset      = 1'b1;
    exp_hits   = 0;
    exp_misses = 0;
    fetch("rmm_030", 10'h030, 1'b1, 6'h03, word_of(10'h030));
    fetch("rmm_000", 10'h000, 1'b1, 6'h00, 32'h0004_0019);
    fetch("rmm_hit_03c", 10'h03C, 1'b0, 6'h00, word_of(10'h03C));
    idle_cycle();
    check_stats("after_rmm");

`ifdef ICACHE_STATS_EN
    // 6 saturation
    force dut.miss_count_q = 16'hFFFF;
    @(negedge clock);
    release dut.miss_count_q;
    fetch("sat_080", 10'h080, 1'b1, 6'h08, word_of(10'h080));
    check("sat_miss_count", {16'd0, miss_count}, 32'h0000_FFFF);
`endif

    check("exp_q_drained", exp_q.size(), 32'd0);

    // ---------------- report ----------------
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
